// File: rtl/apb_req_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_req_bridge_pkg
// Shared types for the valid/ready-to-APB4 request bridge:
//   apb_bridge_state_e : bridge FSM states (2-bit)
//   RESP_OKAY/SLVERR   : encoding of the bridge response error flag
//   apb_req_t/resp_t   : default APB4 request/response structs (32-bit
//                        address and data) used as the bridge's type defaults
// -----------------------------------------------------------------------------
package apb_req_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_bridge_state_e;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 32;

    typedef struct packed {
        logic [DefAddrWidth-1:0]   paddr;
        logic [2:0]                pprot;
        logic                      psel;
        logic                      penable;
        logic                      pwrite;
        logic [DefDataWidth-1:0]   pwdata;
        logic [DefDataWidth/8-1:0] pstrb;
    } apb_req_t;

    typedef struct packed {
        logic                    pready;
        logic [DefDataWidth-1:0] prdata;
        logic                    pslverr;
    } apb_resp_t;

endpackage

// File: rtl/apb_req_bridge.sv
// -----------------------------------------------------------------------------
// apb_req_bridge
// Single-outstanding bridge from a valid/ready register-access request channel
// to an APB4 master port, with completions returned on a valid/ready response
// channel. An optional access-phase timeout abandons transfers to a hung slave.
//
// Ports:
//   pclk_i, preset_ni         clock, synchronous active-low reset
//   req_valid_i/req_ready_o   request handshake
//   req_addr_i/write/wdata/strb/prot   request payload
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_rdata_o, rsp_err_o    read data (0 for writes/timeouts), error flag
//   apb_req_o / apb_resp_i    APB4 request to / response from the slave
// -----------------------------------------------------------------------------
module apb_req_bridge
    import apb_req_bridge_pkg::*;
#(
    parameter int unsigned ApbAddrWidth  = 32'd32,
    parameter int unsigned ApbDataWidth  = 32'd32,
    parameter int unsigned TimeoutCycles = 32'd0,
    parameter type         req_t         = apb_req_t,
    parameter type         resp_t        = apb_resp_t
) (
    input  logic                      pclk_i,
    input  logic                      preset_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [ApbAddrWidth-1:0]   req_addr_i,
    input  logic                      req_write_i,
    input  logic [ApbDataWidth-1:0]   req_wdata_i,
    input  logic [ApbDataWidth/8-1:0] req_strb_i,
    input  logic [2:0]                req_prot_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ApbDataWidth-1:0]   rsp_rdata_o,
    output logic                      rsp_err_o,
    output req_t                      apb_req_o,
    input  resp_t                     apb_resp_i
);

    localparam int unsigned StrbW = ApbDataWidth / 8;
    localparam int unsigned CntW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast =
        (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

    apb_bridge_state_e       state_q;
    logic [ApbAddrWidth-1:0] paddr_q;
    logic [2:0]              pprot_q;
    logic                    pwrite_q;
    logic [ApbDataWidth-1:0] pwdata_q;
    logic [StrbW-1:0]        pstrb_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    rsp_valid_q;
    logic [ApbDataWidth-1:0] rsp_rdata_q;
    logic                    rsp_err_q;
    logic [CntW-1:0]         tmo_cnt_q;
    logic [CntW-1:0]         tmo_cnt_d;
    logic                    timeout_hit;

    // Saturating increment: the counter sticks at all-ones rather than wrap.
    assign tmo_cnt_d   = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + CntW'(1);
    assign timeout_hit = (TimeoutCycles != 0) && (tmo_cnt_q == CntLast);

    always_ff @(posedge pclk_i) begin
        if (!preset_ni) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= RESP_OKAY;
            tmo_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        paddr_q  <= req_addr_i;
                        pprot_q  <= req_prot_i;
                        pwrite_q <= req_write_i;
                        // Reads never carry write data or strobes on the bus.
                        pwdata_q <= req_write_i ? req_wdata_i : '0;
                        pstrb_q  <= req_write_i ? req_strb_i : '0;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    tmo_cnt_q <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // pready is checked first so a late completion beats the timeout.
                    if (apb_resp_i.pready) begin
                        rsp_rdata_q <= pwrite_q ? '0 : apb_resp_i.prdata;
                        rsp_err_q   <= apb_resp_i.pslverr ? RESP_SLVERR : RESP_OKAY;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= RESP_SLVERR;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    always_comb begin
        apb_req_o         = '0;
        apb_req_o.paddr   = paddr_q;
        apb_req_o.pprot   = pprot_q;
        apb_req_o.psel    = psel_q;
        apb_req_o.penable = penable_q;
        apb_req_o.pwrite  = pwrite_q;
        apb_req_o.pwdata  = pwdata_q;
        apb_req_o.pstrb   = pstrb_q;
    end

`ifndef SYNTHESIS
    always_ff @(posedge pclk_i) begin
        assert ((ApbDataWidth % 8 == 0) && (ApbDataWidth >= 8) && (ApbDataWidth <= 32));
        assert (int'($bits(apb_req_o.paddr))   == int'(ApbAddrWidth));
        assert (int'($bits(apb_req_o.pwdata))  == int'(ApbDataWidth));
        assert (int'($bits(apb_req_o.pstrb))   == int'(StrbW));
        assert (int'($bits(apb_resp_i.prdata)) == int'(ApbDataWidth));
    end
`endif

endmodule

// File: tb/tb_apb_req_bridge.sv
module tb_apb_req_bridge;
    import apb_req_bridge_pkg::*;

    localparam int unsigned TC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic [2:0]  req_prot = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    apb_req_t    apb_req;
    apb_resp_t   apb_resp;

    int checks = 0;
    int errors = 0;

    apb_req_bridge #(
        .ApbAddrWidth (32),
        .ApbDataWidth (32),
        .TimeoutCycles(TC),
        .req_t        (apb_req_t),
        .resp_t       (apb_resp_t)
    ) dut (
        .pclk_i     (clk),
        .preset_ni  (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_write_i(req_write),
        .req_wdata_i(req_wdata),
        .req_strb_i (req_strb),
        .req_prot_i (req_prot),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .apb_req_o  (apb_req),
        .apb_resp_i (apb_resp)
    );

    always #5 clk = ~clk;

    // ---------------- APB slave: 0x1000-0x1FFF mapped, rest errors --------------
    logic [31:0] slv_mem [1024];
    logic [31:0] ref_mem [1024];
    int wait_n = 0;
    bit hang = 1'b0;
    int acc_cycles = 0;

    function automatic bit mapped(input logic [31:0] a);
        return a[31:12] == 20'h1;
    endfunction

    always_comb begin
        apb_resp = '0;
        apb_resp.pready = apb_req.psel && apb_req.penable && !hang && (acc_cycles == wait_n);
        if (apb_resp.pready) begin
            if (!mapped(apb_req.paddr)) begin
                apb_resp.pslverr = 1'b1;
                apb_resp.prdata  = 32'h0BAD_B10C;
            end else begin
                // Returns memory content even on writes so the bridge must zero it.
                apb_resp.prdata = slv_mem[apb_req.paddr[11:2]] | 32'h0000_0001;
                if (!apb_req.pwrite) apb_resp.prdata = slv_mem[apb_req.paddr[11:2]];
            end
        end
    end

    always @(posedge clk) begin
        if (apb_req.psel && apb_req.penable && !apb_resp.pready) acc_cycles <= acc_cycles + 1;
        else acc_cycles <= 0;
        if (apb_resp.pready && apb_req.pwrite && mapped(apb_req.paddr)) begin
            for (int b = 0; b < 4; b++)
                if (apb_req.pstrb[b]) slv_mem[apb_req.paddr[11:2]][8*b +: 8] <= apb_req.pwdata[8*b +: 8];
        end
    end

    // ---------------- request start: returns at negedge of SETUP cycle ----------
    task automatic start_req(input logic [31:0] a, input bit w, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p, input bit keep_valid,
                             output bit ok);
        int n = 0;
        req_addr = a; req_write = w; req_wdata = d; req_strb = s; req_prot = p;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_accept: req_ready_o=%0b, required 1 within 50 cycles", req_ready);
            req_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        ok = 1'b1;
        @(negedge clk);
        req_valid = keep_valid;
    endtask

    // ---------------- full transfer against the reference model ----------------
    task automatic run_xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p, input int waits,
                            input bit hng, input int hold, input bit keep_valid);
        bit ok;
        bit bad;
        int k;
        logic [31:0] exp_rd, exp_wd;
        logic [3:0]  exp_st;
        bit exp_err;
        int exp_lat;
        wait_n = waits;
        hang = hng;
        exp_err = hng || !mapped(a);
        exp_rd  = (w || hng) ? 32'h0 : (!mapped(a) ? 32'h0BAD_B10C : ref_mem[a[11:2]]);
        exp_lat = hng ? 2 + int'(TC) : 3 + waits;
        exp_wd  = w ? d : 32'h0;
        exp_st  = w ? s : 4'h0;

        start_req(a, w, d, s, p, keep_valid, ok);
        if (!ok) begin hang = 1'b0; return; end

        checks++;
        if (apb_req.psel !== 1'b1 || apb_req.penable !== 1'b0 || apb_req.paddr !== a ||
            apb_req.pwrite !== w || apb_req.pprot !== p || apb_req.pwdata !== exp_wd ||
            apb_req.pstrb !== exp_st || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL setup: psel=%0b pen=%0b addr=%h wr=%0b prot=%0d wd=%h st=%h, required 1 0 %h %0b %0d %h %h",
                     apb_req.psel, apb_req.penable, apb_req.paddr, apb_req.pwrite, apb_req.pprot,
                     apb_req.pwdata, apb_req.pstrb, a, w, p, exp_wd, exp_st);
        end

        @(negedge clk);
        k = 2;
        bad = 1'b0;
        while (rsp_valid !== 1'b1 && k < 40) begin
            if (apb_req.psel !== 1'b1 || apb_req.penable !== 1'b1 || apb_req.paddr !== a ||
                apb_req.pwdata !== exp_wd || apb_req.pstrb !== exp_st || req_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != exp_lat) begin
            errors++;
            $display("FAIL latency: rsp_valid at cycle %0d, required %0d", k, exp_lat);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL access_stable: access-phase signals changed, got 1 required 0");
        end
        checks++;
        if (apb_req.psel !== 1'b0 || apb_req.penable !== 1'b0) begin
            errors++;
            $display("FAIL resp_psel: psel=%0b penable=%0b, required 0 0", apb_req.psel, apb_req.penable);
        end
        checks++;
        if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
            errors++;
            $display("FAIL resp_data: rdata=%h err=%0b, required %h %0b", rsp_rdata, rsp_err, exp_rd, exp_err);
        end

        if (w && !exp_err)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];

        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== exp_err || req_ready !== 1'b0) bad = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL resp_hold: response unstable or req_ready_o high while held, got 1 required 0");
            end
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || apb_req.psel !== 1'b0 ||
            apb_req.paddr !== a || apb_req.pwrite !== w || apb_req.pprot !== p) begin
            errors++;
            $display("FAIL idle_after: vld=%0b rdy=%0b psel=%0b addr=%h wr=%0b prot=%0d, required 0 1 0 %h %0b %0d",
                     rsp_valid, req_ready, apb_req.psel, apb_req.paddr, apb_req.pwrite, apb_req.pprot, a, w, p);
        end
        hang = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (apb_req !== '0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: apb_req=%h vld=%0b rdata=%h err=%0b rdy=%0b, required 0 0 0 0 1",
                     apb_req, rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        run_xfer(32'h1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_read_wait_states();
        run_xfer(32'h1004, 1'b0, 32'h1234_5678, 4'hF, 3'd2, 2, 1'b0, 0, 1'b0);
    endtask

    task automatic test_slverr();
        run_xfer(32'h3000, 1'b0, 32'h0, 4'h0, 3'd1, 1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_xfer(32'h1010, 1'b1, 32'hCAFE_F00D, 4'hF, 3'd0, 0, 1'b1, 0, 1'b0);
        run_xfer(32'h1010, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_pready_vs_timeout();
        run_xfer(32'h1004, 1'b0, 32'h0, 4'h0, 3'd4, int'(TC) - 1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_xfer(32'h1008, 1'b1, 32'h0102_0304, 4'b0101, 3'd3, 0, 1'b0, 3, 1'b1);
        run_xfer(32'h1008, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'd5, 1, 1'b0, 3, 1'b1);
        run_xfer(32'h100C, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        bit bad;
        wait_n = 0;
        hang = 1'b1;
        start_req(32'h1008, 1'b0, 32'h0, 4'h0, 3'd7, 1'b0, ok);
        if (!ok) begin hang = 1'b0; return; end
        @(negedge clk);
        checks++;
        if (apb_req.psel !== 1'b1 || apb_req.penable !== 1'b1) begin
            errors++;
            $display("FAIL reach_access: psel=%0b penable=%0b, required 1 1", apb_req.psel, apb_req.penable);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (apb_req !== '0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_access: apb_req=%h vld=%0b rdy=%0b, required 0 0 1", apb_req, rsp_valid, req_ready);
        end
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || apb_req.psel !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_resp_after_reset: response or psel seen, got 1 required 0");
        end
        hang = 1'b0;
        run_xfer(32'h1008, 1'b0, 32'h0, 4'h0, 3'd1, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) a = 32'h3000 + 32'($urandom_range(0, 7)) * 4;
            else                           a = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            run_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), int'($urandom_range(0, TC - 1)),
                     ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            slv_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        @(negedge clk);
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_slverr();
        test_timeout();
        test_pready_vs_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_req_bridge.md
Name: apb_req_bridge

Overview:
Single-outstanding bridge that converts a valid/ready register-access request channel into APB4 master transfers. It drives the APB request struct consumed by the APB register file and other APB slaves. It returns each completion on a valid/ready response channel. A configurable access-phase timeout keeps a hung slave from stalling the requester.

Parameters:
ApbAddrWidth, 32'd32, width of paddr and req_addr_i.
ApbDataWidth, 32'd32, width of pwdata/prdata; must be 8..32 and a multiple of 8.
TimeoutCycles, 32'd0, maximum number of ACCESS cycles without pready; 0 disables the timeout.
req_t, logic, APB4 request struct (paddr, pprot, psel, penable, pwrite, pwdata, pstrb).
resp_t, logic, APB4 response struct (pready, prdata, pslverr).

Ports:
pclk_i  input  1  clock; all state on rising edge.
preset_ni  input  1  reset, synchronous, active-low.
req_valid_i  input  1  request valid.
req_ready_o  output  1  request accepted when req_valid_i && req_ready_o.
req_addr_i  input  ApbAddrWidth  byte address.
req_write_i  input  1  1 = write, 0 = read.
req_wdata_i  input  ApbDataWidth  write data.
req_strb_i  input  ApbDataWidth/8  byte strobes.
req_prot_i  input  3  pprot value.
rsp_valid_o  output  1  response valid.
rsp_ready_i  input  1  response consumed when rsp_valid_o && rsp_ready_i.
rsp_rdata_o  output  ApbDataWidth  read data; 0 for writes and timeouts.
rsp_err_o  output  1  1 on pslverr or timeout.
apb_req_o  output  req_t  APB request to the slave.
apb_resp_i  input  resp_t  APB response from the slave.

Behaviour:
- Reset is synchronous and active-low. On the first edge with preset_ni=0, the FSM goes to IDLE from any state, including mid-transfer.
- Reset values: psel=0, penable=0, paddr/pwdata/pstrb/pprot/pwrite=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, timeout counter=0.
- States are IDLE, SETUP, ACCESS and RESP. All outputs are registered or decoded from state only; there is no combinational path from apb_resp_i to apb_req_o.
- IDLE:
  - req_ready_o=1, psel=0, penable=0.
  - On handshake, latch addr/write/prot/strb/wdata into the APB request fields, then go to SETUP.
  - For reads, pwdata and pstrb are driven to 0.
- SETUP: psel=1, penable=0, for exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel=1, penable=1. All request fields stay stable.
  - On pready=1: capture prdata (forced to 0 for writes) and pslverr into the response registers, then go to RESP.
  - If TimeoutCycles>0 and the counter reaches TimeoutCycles-1 with pready=0: rdata=0, err=1, go to RESP. The transfer is abandoned, so psel drops on the next cycle.
  - If pready and the timeout coincide on the same cycle, pready wins and the real response is captured.
- RESP:
  - rsp_valid_o=1, psel=0, penable=0, req_ready_o=0.
  - Hold the response until rsp_ready_i, then go to IDLE.
  - No request/response overlap: the next request is accepted one cycle after the response handshake at the earliest.
- Latency:
  - Handshake at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2.
  - With a zero-wait slave, rsp_valid_o=1 at cycle 3.
  - Each slave wait state adds one cycle.
- After a transfer, paddr/pwrite/pprot hold their last values while psel=0.
- The timeout counter clears on entry to ACCESS and saturates; it never wraps.
- Parameter assertions (simulation only, excluded from synthesis):
  - ApbDataWidth is a multiple of 8 and ≤32.
  - $bits of the struct fields match the parameters.

Decomposition:
- apb_pkg gains apb_bridge_state_e (IDLE, SETUP, ACCESS, RESP; 2-bit). The existing RESP_OKAY/RESP_SLVERR are reused for rsp_err_o mapping.
- Struct typedefs come from the existing APB typedef macros.
- No sub-module. The timeout counter is inline, with width $clog2(TimeoutCycles+1), minimum 1.
- An apb_req_bridge_intf wrapper exposing APB.Master is planned as a separate follow-up.

Test Plan:
- Write 0xDEADBEEF, strb 4'hF to 0x1004, zero-wait slave → setup at cycle 1, access at cycle 2, rsp_valid at cycle 3, err=0, rdata=0.
- Read 0x1004 with 2 wait states, slave returns 0xDEADBEEF → rsp_valid at cycle 5, rdata=0xDEADBEEF, err=0; pwdata=0 and pstrb=0 during the read.
- Read an unmapped address with pslverr=1 and prdata=0x0BADB10C → err=1, rdata=0x0BADB10C.
- TimeoutCycles=4, slave never asserts pready → ACCESS for 4 cycles, psel low next cycle, rsp err=1, rdata=0.
- rsp_ready_i held low for 3 cycles with req_valid_i held high → response stable, req_ready_o=0 throughout; the next request is accepted in IDLE after the response handshake.
- Assert preset_ni=0 for one cycle during ACCESS → psel=0, penable=0 on the following edge; no response is issued; the next request starts cleanly with SETUP.
